// File: rtl/ofmap_pkg.sv
// Shared definitions for the output-feature-map collector: packet field layout,
// the spike packet type code and the collector FSM states.
package ofmap_pkg;

  localparam int unsigned SrcLsb  = 0;
  localparam int unsigned SrcW    = 4;
  localparam int unsigned TypeLsb = 4;
  localparam int unsigned TypeW   = 2;
  localparam int unsigned TsBit   = 6;
  localparam int unsigned RowLsb  = 7;
  localparam int unsigned RowW    = 5;
  localparam int unsigned SpkLsb  = 12;

  localparam logic [TypeW-1:0] TypeSpike = 2'b10;

  typedef enum logic [0:0] {
    StCollect,
    StDone
  } state_e;

endpackage

// File: rtl/ofmap_mem.sv
// Simple dual-port spike-row storage: one write port, one read port with a
// registered, read-first output. Contents are never reset.
module ofmap_mem #(
  parameter int unsigned Depth = 26,
  parameter int unsigned Width = 13,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Non-blocking update gives read-first behaviour on an address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ofmap_collector.sv
// Collects spike-row packets from the mesh output into a timestep x row buffer,
// tracking unique rows, duplicates and malformed drops; the host reads rows back.
module ofmap_collector
  import ofmap_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = 13,
  parameter int unsigned NUM_TS       = 2,
  parameter int unsigned PKT_W        = 45,
  localparam int unsigned Entries     = NUM_TS * OUTPUT_WIDTH,
  localparam int unsigned Aw          = $clog2(Entries),
  localparam int unsigned Cw          = $clog2(Entries + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PKT_W-1:0]        in_data,
  input  logic                    clear,
  input  logic                    rd_en,
  input  logic [Aw-1:0]           rd_addr,
  output logic [OUTPUT_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    done,
  output logic [Cw-1:0]           rows_rcvd,
  output logic                    dup_err,
  output logic [7:0]              drop_cnt
);

  state_e             state_q, state_d;
  logic [Entries-1:0] rcvd_q, rcvd_d;
  logic [Cw-1:0]      rows_q, rows_d;
  logic               dup_q, dup_d;
  logic [7:0]         drop_q, drop_d;
  logic               rd_valid_q;

  logic [TypeW-1:0]        pkt_type;
  logic                    pkt_ts;
  logic [RowW-1:0]         pkt_row;
  logic [OUTPUT_WIDTH-1:0] pkt_spk;
  logic                    pkt_ok, accept, wr_en;
  logic [Aw-1:0]           wr_addr;

  // Source node and bits above the spike field carry nothing for the collector.
  logic unused_pkt_bits;
  assign unused_pkt_bits = ^in_data;

  assign pkt_type = in_data[TypeLsb +: TypeW];
  assign pkt_ts   = in_data[TsBit];
  assign pkt_row  = in_data[RowLsb +: RowW];
  assign pkt_spk  = in_data[SpkLsb +: OUTPUT_WIDTH];

  assign pkt_ok  = (pkt_type == TypeSpike) && (32'(pkt_row) < OUTPUT_WIDTH)
                && (32'(pkt_ts) < NUM_TS);
  assign wr_addr = Aw'(32'(pkt_ts) * OUTPUT_WIDTH + 32'(pkt_row));

  assign in_ready = (state_q == StCollect) && !clear;
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && pkt_ok;

  always_comb begin
    state_d = state_q;
    rcvd_d  = rcvd_q;
    rows_d  = rows_q;
    dup_d   = dup_q;
    drop_d  = drop_q;
    if (clear) begin
      state_d = StCollect;
      rcvd_d  = '0;
      rows_d  = '0;
      dup_d   = 1'b0;
      drop_d  = '0;
    end else if (accept) begin
      if (!pkt_ok) begin
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end else if (rcvd_q[wr_addr]) begin
        dup_d = 1'b1;
      end else begin
        rcvd_d[wr_addr] = 1'b1;
        rows_d          = rows_q + Cw'(1);
        if (rows_q == Cw'(Entries - 1)) begin
          state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCollect;
      rcvd_q     <= '0;
      rows_q     <= '0;
      dup_q      <= 1'b0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rcvd_q     <= rcvd_d;
      rows_q     <= rows_d;
      dup_q      <= dup_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_en;
    end
  end

  // A packet in flight while reset is asserted must not land in storage.
  ofmap_mem #(
    .Depth (Entries),
    .Width (OUTPUT_WIDTH),
    .Aw    (Aw)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en && !rst),
    .waddr_i (wr_addr),
    .wdata_i (pkt_spk),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign done      = (state_q == StDone);
  assign rows_rcvd = rows_q;
  assign dup_err   = dup_q;
  assign drop_cnt  = drop_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ofmap_collector.sv
// Randomized bench for ofmap_collector against a behavioural collection model.
module tb_ofmap_collector;

  localparam int OW  = 13;
  localparam int NT  = 2;
  localparam int PW  = 45;
  localparam int N   = NT * OW;
  localparam int AW  = $clog2(N);
  localparam int CW  = $clog2(N + 1);
  localparam int AW1 = $clog2(OW);
  localparam int CW1 = $clog2(OW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, in_valid = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          in_ready, rd_valid, done, dup_err;
  logic [OW-1:0] rd_data;
  logic [CW-1:0] rows_rcvd;
  logic [7:0]    drop_cnt;

  // Second instance with a single timestep, for the out-of-range timestep case.
  logic           in1_valid = 1'b0, clear1 = 1'b0, rd1_en = 1'b0;
  logic [PW-1:0]  in1_data = '0;
  logic [AW1-1:0] rd1_addr = '0;
  logic           in1_ready, rd1_valid, done1, dup1_err;
  logic [OW-1:0]  rd1_data;
  logic [CW1-1:0] rows1_rcvd;
  logic [7:0]     drop1_cnt;

  ofmap_collector #(.OUTPUT_WIDTH(OW), .NUM_TS(NT), .PKT_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .done(done), .rows_rcvd(rows_rcvd), .dup_err(dup_err),
    .drop_cnt(drop_cnt)
  );

  ofmap_collector #(.OUTPUT_WIDTH(OW), .NUM_TS(1), .PKT_W(PW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
    .clear(clear1), .rd_en(rd1_en), .rd_addr(rd1_addr), .rd_data(rd1_data),
    .rd_valid(rd1_valid), .done(done1), .rows_rcvd(rows1_rcvd), .dup_err(dup1_err),
    .drop_cnt(drop1_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the main instance: stored rows, which are known, and collection status.
  logic [OW-1:0] m_mem [N];
  bit            m_rcvd [N];
  int            m_rows, m_drop;
  bit            m_dup;

  function automatic logic [PW-1:0] mk(input int ts, input int row, input int typ,
                                       input logic [OW-1:0] spk);
    logic [PW-1:0] p;
    p        = PW'({$urandom, $urandom});
    p[5:4]   = 2'(typ);
    p[6]     = 1'(ts);
    p[11:7]  = 5'(row);
    p[24:12] = spk;
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_rcvd[i] = 1'b0;
    m_rows = 0;
    m_drop = 0;
    m_dup  = 1'b0;
  endtask

  task automatic model_pkt(input int ts, input int row, input int typ, input logic [OW-1:0] spk);
    int a;
    if (typ == 2 && row < OW && ts < NT) begin
      a = ts * OW + row;
      if (m_rcvd[a]) m_dup = 1'b1;
      else begin
        m_rcvd[a] = 1'b1;
        m_rows++;
      end
      m_mem[a] = spk;
    end else if (m_drop < 255) begin
      m_drop++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ts, input int row, input int typ, input logic [OW-1:0] spk);
    in_valid = 1'b1;
    in_data  = mk(ts, row, typ, spk);
  endtask

  task automatic rd(input int a, output logic [OW-1:0] d, output logic v);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    step();
    rd_en = 1'b0;
    d     = rd_data;
    v     = rd_valid;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_clear();
  endtask

  // Sends all entries in a random order back to back, then reads everything back.
  task automatic collect_all(input string tag);
    int            perm [N];
    int            j, t;
    logic [OW-1:0] spk, d;
    logic          v;
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < N; k++) begin
      spk = OW'($urandom);
      drive(perm[k] / OW, perm[k] % OW, 2, spk);
      model_pkt(perm[k] / OW, perm[k] % OW, 2, spk);
      step();
      n_tests++;
      if (rows_rcvd !== CW'(m_rows) || done !== (k == N - 1)) begin
        n_fail++;
        $display("FAIL %s_progress k=%0d: rows=%0d done=%b, required rows=%0d done=%b",
                 tag, k, rows_rcvd, done, m_rows, (k == N - 1));
      end
    end
    in_valid = 1'b0;
    for (int a = 0; a < N; a++) begin
      rd(a, d, v);
      n_tests++;
      if (v !== 1'b1 || d !== m_mem[a]) begin
        n_fail++;
        $display("FAIL %s_read addr=%0d: data=%h valid=%b, required %h valid=1",
                 tag, a, d, v, m_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_clear();
    n_tests++;
    if (done !== 1'b0 || rows_rcvd !== '0 || dup_err !== 1'b0 || drop_cnt !== 8'd0
        || rd_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: done=%b rows=%0d dup=%b drop=%0d rdv=%b rdy=%b, required 0 0 0 0 0 1",
               done, rows_rcvd, dup_err, drop_cnt, rd_valid, in_ready);
    end
  endtask

  task automatic test_full_collection();
    logic [OW-1:0] d, spk;
    logic          v;
    collect_all("full");
    step();
    n_tests++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_valid_idle: got %b, required 0", rd_valid);
    end
    // Held valid in DONE must be refused and must not disturb storage.
    spk = ~m_mem[0];
    drive(0, 0, 2, spk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_backpressure: in_ready=%b, required 0", in_ready);
    end
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    n_tests++;
    if (rows_rcvd !== CW'(N) || done !== 1'b1 || dup_err !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: rows=%0d done=%b dup=%b, required %0d 1 0", rows_rcvd, done, dup_err, N);
    end
    rd(0, d, v);
    n_tests++;
    if (d !== m_mem[0]) begin
      n_fail++;
      $display("FAIL done_no_write: data=%h, required %h", d, m_mem[0]);
    end
    // Clear together with a valid packet: refused, counters zeroed, storage kept.
    clear = 1'b1;
    drive(0, 0, 2, spk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: in_ready=%b, required 0", in_ready);
    end
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (done !== 1'b0 || rows_rcvd !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_state: done=%b rows=%0d rdy=%b, required 0 0 1", done, rows_rcvd, in_ready);
    end
    rd(0, d, v);
    n_tests++;
    if (d !== m_mem[0]) begin
      n_fail++;
      $display("FAIL clear_retains: data=%h, required %h", d, m_mem[0]);
    end
  endtask

  task automatic test_malformed();
    int            ts_l  [3] = '{0, 1, 0};
    int            row_l [3] = '{2, 13, 9};
    int            typ_l [3] = '{1, 2, 3};
    logic [OW-1:0] spk, d;
    logic          v;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      spk = OW'($urandom);
      drive(ts_l[i], row_l[i], typ_l[i], spk);
      model_pkt(ts_l[i], row_l[i], typ_l[i], spk);
      step();
      n_tests++;
      if (drop_cnt !== 8'(m_drop) || rows_rcvd !== CW'(m_rows)) begin
        n_fail++;
        $display("FAIL malformed_%0d: drop=%0d rows=%0d, required %0d %0d",
                 i, drop_cnt, rows_rcvd, m_drop, m_rows);
      end
    end
    in_valid = 1'b0;
    rd(2, d, v);
    n_tests++;
    if (d !== m_mem[2]) begin
      n_fail++;
      $display("FAIL malformed_no_write: data=%h, required %h", d, m_mem[2]);
    end
    // Timestep 1 is out of range on the single-timestep instance.
    in1_valid = 1'b1;
    in1_data  = mk(1, 3, 2, OW'($urandom));
    step();
    n_tests++;
    if (drop1_cnt !== 8'd1 || rows1_rcvd !== '0) begin
      n_fail++;
      $display("FAIL bad_ts: drop=%0d rows=%0d, required 1 0", drop1_cnt, rows1_rcvd);
    end
    in1_data = mk(0, 3, 2, OW'($urandom));
    step();
    in1_valid = 1'b0;
    n_tests++;
    if (drop1_cnt !== 8'd1 || rows1_rcvd !== CW1'(1)) begin
      n_fail++;
      $display("FAIL ts0_on_single: drop=%0d rows=%0d, required 1 1", drop1_cnt, rows1_rcvd);
    end
    // Saturation of the drop counter.
    for (int i = 0; i < 260; i++) begin
      spk = OW'($urandom);
      drive(0, 13 + (i % 19), 2, spk);
      model_pkt(0, 13 + (i % 19), 2, spk);
      step();
    end
    in_valid = 1'b0;
    n_tests++;
    if (drop_cnt !== 8'(m_drop) || m_drop != 255) begin
      n_fail++;
      $display("FAIL drop_saturate: drop=%0d, required 255", drop_cnt);
    end
    do_clear();
    n_tests++;
    if (drop_cnt !== 8'd0 || rows_rcvd !== '0) begin
      n_fail++;
      $display("FAIL drop_clear: drop=%0d rows=%0d, required 0 0", drop_cnt, rows_rcvd);
    end
  endtask

  task automatic test_duplicate();
    logic [OW-1:0] d;
    logic          v;
    do_clear();
    drive(0, 5, 2, 13'h0AAA);
    model_pkt(0, 5, 2, 13'h0AAA);
    step();
    n_tests++;
    if (dup_err !== 1'b0 || rows_rcvd !== CW'(1)) begin
      n_fail++;
      $display("FAIL dup_first: dup=%b rows=%0d, required 0 1", dup_err, rows_rcvd);
    end
    drive(0, 5, 2, 13'h1555);
    model_pkt(0, 5, 2, 13'h1555);
    step();
    in_valid = 1'b0;
    n_tests++;
    if (dup_err !== 1'b1 || rows_rcvd !== CW'(1)) begin
      n_fail++;
      $display("FAIL dup_second: dup=%b rows=%0d, required 1 1", dup_err, rows_rcvd);
    end
    rd(5, d, v);
    n_tests++;
    if (d !== 13'h1555) begin
      n_fail++;
      $display("FAIL dup_overwrite: data=%h, required 1555", d);
    end
    step();
    n_tests++;
    if (dup_err !== 1'b1) begin
      n_fail++;
      $display("FAIL dup_sticky: dup=%b, required 1", dup_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] d, spk;
    logic          v;
    do_clear();
    for (int a = 0; a < 10; a++) begin
      spk = OW'($urandom);
      drive((a * 3) / OW, (a * 3) % OW, 2, spk);
      model_pkt((a * 3) / OW, (a * 3) % OW, 2, spk);
      step();
    end
    n_tests++;
    if (rows_rcvd !== CW'(10)) begin
      n_fail++;
      $display("FAIL mid_rows: rows=%0d, required 10", rows_rcvd);
    end
    // Packet for entry 25 arrives with reset; it must be lost.
    drive(1, 12, 2, ~m_mem[25]);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    model_clear();
    n_tests++;
    if (rows_rcvd !== '0 || done !== 1'b0 || dup_err !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rows=%0d done=%b dup=%b rdv=%b, required 0 0 0 0",
               rows_rcvd, done, dup_err, rd_valid);
    end
    rd(25, d, v);
    n_tests++;
    if (d !== m_mem[25]) begin
      n_fail++;
      $display("FAIL mid_reset_no_write: data=%h, required %h", d, m_mem[25]);
    end
    collect_all("resume");
  endtask

  task automatic test_read_during_write();
    logic [OW-1:0] old_v, new_v, d;
    logic          v;
    do_clear();
    old_v   = m_mem[7];
    new_v   = old_v ^ (OW'($urandom) | OW'(1));
    rd_en   = 1'b1;
    rd_addr = AW'(7);
    drive(0, 7, 2, new_v);
    model_pkt(0, 7, 2, new_v);
    step();
    rd_en    = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== old_v) begin
      n_fail++;
      $display("FAIL rdw_old: data=%h valid=%b, required %h 1", rd_data, rd_valid, old_v);
    end
    rd(7, d, v);
    n_tests++;
    if (d !== new_v || v !== 1'b1) begin
      n_fail++;
      $display("FAIL rdw_new: data=%h valid=%b, required %h 1", d, v, new_v);
    end
  endtask

  initial begin
    test_reset();
    test_full_collection();
    test_malformed();
    test_duplicate();
    test_reset_mid();
    test_read_during_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
